// File: rtl/dts_sync_aligner.sv
// rtl/dts_sync_aligner.sv - measures sync skew across offsetter streams and pulses delay requests until all syncs coincide
//
// Optional feature: define DTS_SYNC_ALIGNER_LOSS_CNT_EN to build the saturating
// lock-loss counter; otherwise lock_loss_count_o is tied to zero.
//
// Ports:
//   clk_i             common output clock, rising edge
//   rst_i             synchronous active-high reset
//   enable_i          1 = run alignment, 0 = return to IDLE (clears error)
//   sync_i            per-stream dout_sync from the offsetters
//   delay_o           per-stream delay request back to the offsetters
//   aligned_o         all streams locked
//   error_o           sticky fault: measurement timeout or non-integer word skew
//   skew_max_o        last measured max arrival offset, in clocks
//   lock_loss_count_o number of LOCKED->WAIT transitions (saturating)
module dts_sync_aligner #(
    parameter int N_STREAMS    = 4,
    parameter int MAX_SKEW     = 64,
    parameter int WORD_CYCLES  = 1,
    parameter int PULSE_CYCLES = 4,
    parameter int VERIFY_SYNCS = 2,
    localparam int CNT_W       = $clog2(MAX_SKEW + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [N_STREAMS-1:0] sync_i,
    output logic [N_STREAMS-1:0] delay_o,
    output logic                 aligned_o,
    output logic                 error_o,
    output logic [CNT_W-1:0]     skew_max_o,
    output logic [15:0]          lock_loss_count_o
);

    localparam int IDX_W = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;
    localparam int PH_W  = $clog2(2 * PULSE_CYCLES + 1);
    localparam int VC_W  = $clog2(VERIFY_SYNCS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MEASURE,
        S_ADJUST,
        S_VERIFY,
        S_LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_STREAMS-1:0]   arrived_q, arrived_d;
    logic [CNT_W-1:0]       arr_q [N_STREAMS];
    logic [CNT_W-1:0]       arr_d [N_STREAMS];
    logic [CNT_W-1:0]       dly_q [N_STREAMS];
    logic [CNT_W-1:0]       dly_d [N_STREAMS];
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [VC_W-1:0]        vcnt_q, vcnt_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       skew_q, skew_d;

    // Window bookkeeping as seen in the current cycle, including this cycle's syncs.
    logic [CNT_W-1:0]       meas_cnt;
    logic [N_STREAMS-1:0]   arrived_base, arrived_now;
    logic [CNT_W-1:0]       arr_now [N_STREAMS];
    logic [CNT_W-1:0]       diff_now [N_STREAMS];
    logic [CNT_W-1:0]       pulses_now [N_STREAMS];
    logic [CNT_W-1:0]       arr_max, arr_min;
    logic                   rem_bad, any_pulse, all_now;
    logic                   sync_event, all_sync, partial;
    logic                   close;
    logic [IDX_W-1:0]       cur;
    logic                   pulse_end, more_left;

    assign sync_event = |sync_i;
    assign all_sync   = &sync_i;
    assign partial    = sync_event && !all_sync;

    always_comb begin
        // In WAIT the window opens this cycle, so earlier arrivals are stale.
        meas_cnt     = (state_q == S_WAIT) ? '0 : cnt_q;
        arrived_base = (state_q == S_WAIT) ? '0 : arrived_q;
        arrived_now  = arrived_base | sync_i;
        all_now      = &arrived_now;
        for (int i = 0; i < N_STREAMS; i++) begin
            arr_now[i] = arrived_base[i] ? arr_q[i] : meas_cnt;
        end
        arr_max = '0;
        arr_min = '1;
        for (int i = 0; i < N_STREAMS; i++) begin
            if (arr_now[i] > arr_max) arr_max = arr_now[i];
            if (arr_now[i] < arr_min) arr_min = arr_now[i];
        end
        rem_bad   = 1'b0;
        any_pulse = 1'b0;
        for (int i = 0; i < N_STREAMS; i++) begin
            diff_now[i]   = arr_max - arr_now[i];
            pulses_now[i] = diff_now[i] / CNT_W'(WORD_CYCLES);
            if ((diff_now[i] % CNT_W'(WORD_CYCLES)) != '0) rem_bad = 1'b1;
            if (pulses_now[i] != '0) any_pulse = 1'b1;
        end
    end

    // The stream being serviced is always the lowest one with pulses left, so
    // streams needing no pulses are skipped without spending a cycle.
    always_comb begin
        cur = '0;
        for (int i = N_STREAMS - 1; i >= 0; i--) begin
            if (dly_q[i] != '0) cur = IDX_W'(i);
        end
        pulse_end = (ph_q == PH_W'(2 * PULSE_CYCLES - 1));
        more_left = 1'b0;
        for (int i = 0; i < N_STREAMS; i++) begin
            if (IDX_W'(i) == cur) begin
                if (dly_q[i] > CNT_W'(1)) more_left = 1'b1;
            end else if (dly_q[i] != '0) begin
                more_left = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arrived_d = arrived_q;
        arr_d     = arr_q;
        dly_d     = dly_q;
        ph_d      = ph_q;
        vcnt_d    = vcnt_q;
        err_d     = err_q;
        skew_d    = skew_q;
        close     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sync_event) begin
                    arrived_d = arrived_now;
                    arr_d     = arr_now;
                    cnt_d     = CNT_W'(1);
                    if (all_now) close = 1'b1;
                    else         state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                arrived_d = arrived_now;
                arr_d     = arr_now;
                cnt_d     = cnt_q + CNT_W'(1);
                if (all_now) begin
                    close = 1'b1;
                end else if (cnt_q == CNT_W'(MAX_SKEW)) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_ADJUST: begin
                ph_d = ph_q + PH_W'(1);
                if (pulse_end) begin
                    ph_d       = '0;
                    dly_d[cur] = dly_q[cur] - CNT_W'(1);
                    if (!more_left) begin
                        vcnt_d  = '0;
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (all_sync) begin
                    if (vcnt_q == VC_W'(VERIFY_SYNCS - 1)) state_d = S_LOCKED;
                    else                                   vcnt_d  = vcnt_q + VC_W'(1);
                end else if (partial) begin
                    state_d = S_WAIT;
                end
            end
            S_LOCKED: begin
                if (partial) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase

        if (close) begin
            skew_d = arr_max - arr_min;
            if (rem_bad) begin
                err_d   = 1'b1;
                state_d = S_WAIT;
            end else if (any_pulse) begin
                dly_d   = pulses_now;
                ph_d    = '0;
                state_d = S_ADJUST;
            end else begin
                vcnt_d  = '0;
                state_d = S_VERIFY;
            end
        end

        if (!enable_i) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            arrived_q <= '0;
            ph_q      <= '0;
            vcnt_q    <= '0;
            err_q     <= 1'b0;
            skew_q    <= '0;
            for (int i = 0; i < N_STREAMS; i++) begin
                arr_q[i] <= '0;
                dly_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arrived_q <= arrived_d;
            arr_q     <= arr_d;
            dly_q     <= dly_d;
            ph_q      <= ph_d;
            vcnt_q    <= vcnt_d;
            err_q     <= err_d;
            skew_q    <= skew_d;
        end
    end

    // Pulse high for the first half of each 2*PULSE_CYCLES slot, low for the second.
    always_comb begin
        for (int i = 0; i < N_STREAMS; i++) begin
            delay_o[i] = (state_q == S_ADJUST) && (ph_q < PH_W'(PULSE_CYCLES)) &&
                         (cur == IDX_W'(i));
        end
    end

    assign aligned_o  = (state_q == S_LOCKED);
    assign error_o    = err_q;
    assign skew_max_o = skew_q;

`ifdef DTS_SYNC_ALIGNER_LOSS_CNT_EN
    logic [15:0] llc_q, llc_d;
    logic        llc_inc;

    assign llc_inc = (state_q == S_LOCKED) && enable_i && partial;

    always_comb begin
        llc_d = llc_q;
        if (llc_inc && (llc_q != 16'hFFFF)) llc_d = llc_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) llc_q <= '0;
        else       llc_q <= llc_d;
    end

    assign lock_loss_count_o = llc_q;
`else
    assign lock_loss_count_o = '0;
`endif

endmodule

// File: tb/tb_dts_sync_aligner.sv
// tb/tb_dts_sync_aligner.sv - self-checking bench for dts_sync_aligner with an offsetter slip model
`timescale 1ns/1ps
module tb_dts_sync_aligner;
    localparam int N      = 4;
    localparam int PERIOD = 200;
    localparam int PW     = 4;
    localparam int NEVER  = 1 << 30;

    typedef struct packed {
        logic              sel;
        logic [N-1:0][7:0] off;
        logic [N-1:0][7:0] edg;
        logic [7:0]        skew;
        logic              err;
        logic [15:0]       ecyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst, en1, en2;
    logic [N-1:0] sync;
    logic [N-1:0] delay1, delay2;
    logic aligned1, aligned2, error1, error2;
    logic [6:0] skew1, skew2;
    logic [15:0] llc1, llc2;

    always #5 clk = ~clk;

    dts_sync_aligner #(.N_STREAMS(4), .MAX_SKEW(64), .WORD_CYCLES(1),
                       .PULSE_CYCLES(4), .VERIFY_SYNCS(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .sync_i(sync),
        .delay_o(delay1), .aligned_o(aligned1), .error_o(error1),
        .skew_max_o(skew1), .lock_loss_count_o(llc1));

    dts_sync_aligner #(.N_STREAMS(4), .MAX_SKEW(64), .WORD_CYCLES(2),
                       .PULSE_CYCLES(4), .VERIFY_SYNCS(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .enable_i(en2), .sync_i(sync),
        .delay_o(delay2), .aligned_o(aligned2), .error_o(error2),
        .skew_max_o(skew2), .lock_loss_count_o(llc2));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ph [N];
    int edges [N];
    int hi_len, lo_len;
    bit had_fall;
    logic dsel = 1'b0;
    logic [N-1:0] dly_prev = '0;
    logic al_prev = 1'b0, er_prev = 1'b0;
    int al_rise, al_fall, er_rise;
    vec_t vecs [6];
    vec_t sb [$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic sel, input int o0, input int o1, input int o2,
                                input int o3, input int e0, input int e1, input int e2,
                                input int e3, input int sk, input logic er, input int ec);
        vec_t v;
        v.sel    = sel;
        v.off[0] = 8'(o0); v.off[1] = 8'(o1); v.off[2] = 8'(o2); v.off[3] = 8'(o3);
        v.edg[0] = 8'(e0); v.edg[1] = 8'(e1); v.edg[2] = 8'(e2); v.edg[3] = 8'(e3);
        v.skew   = 8'(sk);
        v.err    = er;
        v.ecyc   = 16'(ec);
        return v;
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < N; i++) edges[i] = 0;
        dly_prev = '0;
        hi_len   = 0;
        lo_len   = 0;
        had_fall = 1'b0;
        al_rise  = -1;
        al_fall  = -1;
        er_rise  = -1;
    endtask

    // One clock: observe the posedge that just happened, then drive sync for the next one.
    task automatic step();
        logic [N-1:0] dly;
        logic al, er;
        int wc;
        @(negedge clk);
        dly = dsel ? delay2 : delay1;
        al  = dsel ? aligned2 : aligned1;
        er  = dsel ? error2 : error1;
        wc  = dsel ? 2 : 1;
        if (dly != '0) check("delay_onehot", $countones(dly), 1);
        for (int i = 0; i < N; i++) begin
            if (dly[i] && !dly_prev[i]) begin
                edges[i]++;
                ph[i] += wc;
            end
        end
        if (dly != '0) begin
            if (dly_prev == '0) begin
                if (had_fall) check("pulse_low_len", lo_len, PW);
                hi_len = 1;
            end else begin
                hi_len++;
            end
        end else begin
            if (dly_prev != '0) begin
                check("pulse_high_len", hi_len, PW);
                had_fall = 1'b1;
                lo_len   = 1;
            end else begin
                lo_len++;
            end
        end
        if (al && !al_prev && al_rise < 0) al_rise = cyc;
        if (!al && al_prev && al_fall < 0) al_fall = cyc;
        if (er && !er_prev && er_rise < 0) er_rise = cyc;
        dly_prev = dly;
        al_prev  = al;
        er_prev  = er;
        cyc++;
        for (int i = 0; i < N; i++) sync[i] = (cyc >= ph[i]) && (((cyc - ph[i]) % PERIOD) == 0);
    endtask

    // kind: 0 aligned rise, 1 error rise, 2 aligned fall, 3 delay[1] high
    task automatic run_until(input int kind, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            step();
            if ((kind == 0 && al_rise >= 0) || (kind == 1 && er_rise >= 0) ||
                (kind == 2 && al_fall >= 0) || (kind == 3 && dly_prev[1])) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        for (int i = 0; i < N; i++) ph[i] = NEVER;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        vec_t v, e;
        bit ok;
        int base, mx, mn;
        int ph_snap [N];

        sync = '0;
        rst  = 1'b1;
        en1  = 1'b0;
        en2  = 1'b0;
        clear_obs();

        vecs[0] = mk(1'b0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1'b0, 400);
        vecs[1] = mk(1'b0, 0, 0, 3, 0,   3, 3, 0, 3,  3, 1'b0, 403);
        vecs[2] = mk(1'b0, 1, 0, 2, 0,   1, 2, 0, 2,  2, 1'b0, 402);
        vecs[3] = mk(1'b0, 0, 255, 0, 0, 0, 0, 0, 0,  0, 1'b1, 64);
        vecs[4] = mk(1'b1, 0, 3, 0, 0,   0, 0, 0, 0,  3, 1'b1, 3);
        vecs[5] = mk(1'b1, 0, 0, 4, 0,   2, 2, 0, 2,  4, 1'b0, 404);

        do_reset();
        check("rst_delay1", delay1, 0);
        check("rst_delay2", delay2, 0);
        check("rst_aligned1", aligned1, 0);
        check("rst_aligned2", aligned2, 0);
        check("rst_error1", error1, 0);
        check("rst_error2", error2, 0);
        check("rst_skew1", skew1, 0);
        check("rst_skew2", skew2, 0);
        check("rst_llc1", llc1, 0);
        check("rst_llc2", llc2, 0);

        for (int r = 0; r < 6; r++) begin
            v = vecs[r];
            do_reset();
            dsel = v.sel;
            clear_obs();
            base = cyc + 10;
            for (int i = 0; i < N; i++) ph[i] = (v.off[i] == 8'hFF) ? NEVER : base + int'(v.off[i]);
            if (v.sel) en2 = 1'b1;
            else       en1 = 1'b1;
            sb.push_back(v);
            run_until(v.err ? 1 : 0, 1200, ok);
            check($sformatf("row%0d_done", r), ok, 1);
            e = sb.pop_front();
            for (int i = 0; i < N; i++)
                check($sformatf("row%0d_edges%0d", r, i), edges[i], e.edg[i]);
            check($sformatf("row%0d_skew", r), dsel ? skew2 : skew1, e.skew);
            check($sformatf("row%0d_error", r), dsel ? error2 : error1, e.err);
            check($sformatf("row%0d_aligned", r), dsel ? aligned2 : aligned1, !e.err);
            check($sformatf("row%0d_cycle", r), (e.err ? er_rise : al_rise) - base, e.ecyc);
            en1 = 1'b0;
            en2 = 1'b0;
            step();
            check($sformatf("row%0d_err_cleared", r), dsel ? error2 : error1, 0);
            check($sformatf("row%0d_aligned_cleared", r), dsel ? aligned2 : aligned1, 0);
        end

        // Lock, slip stream 0 by one clock, expect loss and a one-pulse relock.
        do_reset();
        dsel = 1'b0;
        clear_obs();
        base = cyc + 10;
        for (int i = 0; i < N; i++) ph[i] = base;
        en1 = 1'b1;
        run_until(0, 1200, ok);
        check("slip_lock", ok, 1);
        ph[0] += 1;
        clear_obs();
        run_until(2, 400, ok);
        check("slip_loss_seen", ok, 1);
        check("slip_loss_cycle", al_fall - base, 600);
`ifdef DTS_SYNC_ALIGNER_LOSS_CNT_EN
        check("slip_llc", llc1, 1);
`else
        check("slip_llc", llc1, 0);
`endif
        clear_obs();
        run_until(0, 1500, ok);
        check("slip_relock", ok, 1);
        check("slip_edges0", edges[0], 0);
        check("slip_edges1", edges[1], 1);
        check("slip_edges2", edges[2], 1);
        check("slip_edges3", edges[3], 1);

        // Drop enable while delay[1] is high, then re-enable and relock.
        do_reset();
        dsel = 1'b0;
        clear_obs();
        base = cyc + 10;
        ph[0] = base; ph[1] = base; ph[2] = base + 3; ph[3] = base;
        en1 = 1'b1;
        run_until(3, 400, ok);
        check("drop_d1_high", ok, 1);
        en1 = 1'b0;
        clear_obs();
        step();
        check("drop_delay", delay1, 0);
        check("drop_aligned", aligned1, 0);
        check("drop_error", error1, 0);
        mx = ph[0];
        mn = ph[0];
        for (int i = 0; i < N; i++) begin
            ph_snap[i] = ph[i];
            if (ph[i] > mx) mx = ph[i];
            if (ph[i] < mn) mn = ph[i];
        end
        en1 = 1'b1;
        run_until(0, 1500, ok);
        check("reen_lock", ok, 1);
        check("reen_skew", skew1, mx - mn);
        check("reen_error", error1, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("reen_edges%0d", i), edges[i], mx - ph_snap[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
